upload_arbiter: RTL
===================

Name: upload_arbiter

Overview:
- Merges the framed byte streams of up to NUM_CH upload packers into a single upload byte stream that feeds the USB/UART transmit path.
- Arbitration is round-robin. A grant is held for a whole frame, so bytes from different sources never interleave.
- A watchdog releases a grant that has stalled, so one hung channel cannot block the others.

Parameters:
- NUM_CH, 4, number of input channels (2..8).
- TIMEOUT_CYCLES, 16'd1000, consecutive no-transfer cycles before a grant is forcibly released; 0 disables the watchdog.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset: asynchronous, active-low.
- in_req  input  NUM_CH  per-channel frame request; held high for the whole frame.
- in_data  input  NUM_CH*8  flattened per-channel byte; channel i occupies [8i+7:8i].
- in_source  input  NUM_CH*8  flattened per-channel source ID.
- in_valid  input  NUM_CH  per-channel byte valid.
- in_ready  output  NUM_CH  per-channel ready; only the granted bit can be 1.
- out_req  output  1  frame request to the transmit path.
- out_data  output  8  muxed byte.
- out_source  output  8  muxed source ID.
- out_valid  output  1  muxed valid.
- out_ready  input  1  transmit path accepts a byte.
- grant  output  NUM_CH  one-hot current grant; 0 when idle.
- busy  output  1  high while in GRANT.
- timeout_pulse  output  1  one-cycle pulse when the watchdog releases a grant.

Behaviour:
- Reset values: grant=0, state=IDLE, rr_ptr=0, wd_cnt=0, timeout_pulse=0, busy=0.
  - Consequently out_req, out_valid and in_ready are all 0, and out_data=out_source=0.
- State IDLE:
  - If any in_req bit is high, search channels starting at rr_ptr and wrapping modulo NUM_CH.
  - Register a one-hot grant for the first requesting channel g, clear wd_cnt and go to GRANT.
  - Grant latency is 1 cycle after in_req is sampled.
- State GRANT, combinational mux from channel g:
  - out_req=in_req[g], out_valid=in_valid[g], out_data=in_data[g], out_source=in_source[g].
  - in_ready[g]=out_ready; all other in_ready bits are 0.
  - A byte transfers on any cycle with out_valid and out_ready both high.
  - The arbiter adds no storage and no extra latency on the data path.
- GRANT exits to IDLE when either of the following holds:
  - in_req[g] is sampled low (normal end of frame);
  - wd_cnt reaches TIMEOUT_CYCLES-1 while TIMEOUT_CYCLES≠0; on this cycle assert timeout_pulse for 1 cycle.
- On either exit: rr_ptr <= (g+1) mod NUM_CH, grant <= 0.
  - At least one IDLE cycle always separates consecutive frames.
  - While in IDLE, out_req=0 and out_valid=0.
- Watchdog (wd_cnt, 16 bit):
  - Clears on every transfer and on entry to GRANT.
  - Otherwise increments in GRANT and saturates at 16'hFFFF.
- Requests on other channels during GRANT are ignored; they are re-evaluated in IDLE.
- Fairness: with all channels requesting continuously, grants rotate 0,1,2,…,NUM_CH-1,0.
- A channel that drops in_req while not granted is simply not selected. No request latching.
- Reset asserted mid-frame: the arbiter returns to IDLE immediately (asynchronous), and all outputs drop to their reset values in the same instant.
- in_valid on a non-granted channel has no effect, and that channel sees in_ready=0.

Test Plan:
- Single channel: ch1 sends the 7-byte frame AA 44 02 00 01 5A 35 with out_ready=1.
  - grant=4'b0010 one cycle after in_req[1] rises.
  - out_data reproduces all 7 bytes in order with out_source=0x02.
  - grant=0 one cycle after in_req[1] falls.
- Simultaneous requests: ch0 and ch2 request at the same time after reset, 4-byte frames each.
  - ch0 is served fully first, then one IDLE cycle, then ch2.
  - No bytes are interleaved; rr_ptr=3 at the end.
- Round-robin: all 4 channels request continuously.
  - The grant sequence over 8 frames is 0,1,2,3,0,1,2,3.
- Backpressure: out_ready toggles 1,0,0,1 while ch3 streams.
  - in_ready[3] mirrors out_ready exactly, and in_ready[0..2] stay 0.
  - Every byte is delivered once with no duplicates and no losses.
- Watchdog: TIMEOUT_CYCLES=8; ch0 holds in_req=1 with in_valid=0.
  - timeout_pulse fires on the 8th cycle after the grant.
  - Grant then moves to the pending ch1.
- Reset mid-frame: assert rst_n=0 after 3 bytes of a ch2 frame.
  - grant=0, out_valid=0 and out_req=0 immediately.
  - After release, the first arbitration starts from ch0.

Source files
------------

// File: rtl/upload_arbiter_if.sv
// rtl/upload_arbiter_if.sv - per-channel upload inputs and merged upload stream of the upload arbiter
interface upload_arbiter_if #(
  parameter int NUM_CH = 4
);
  logic [NUM_CH-1:0]   in_req;
  logic [NUM_CH*8-1:0] in_data;
  logic [NUM_CH*8-1:0] in_source;
  logic [NUM_CH-1:0]   in_valid;
  logic [NUM_CH-1:0]   in_ready;
  logic                out_req;
  logic [7:0]          out_data;
  logic [7:0]          out_source;
  logic                out_valid;
  logic                out_ready;
  logic [NUM_CH-1:0]   grant;
  logic                busy;
  logic                timeout_pulse;

  // master is the arbiter side, slave is the packers plus transmit path
  modport master (
    input  in_req, in_data, in_source, in_valid, out_ready,
    output in_ready, out_req, out_data, out_source, out_valid, grant, busy, timeout_pulse
  );

  modport slave (
    output in_req, in_data, in_source, in_valid, out_ready,
    input  in_ready, out_req, out_data, out_source, out_valid, grant, busy, timeout_pulse
  );
endinterface

// File: rtl/upload_arbiter.sv
// rtl/upload_arbiter.sv - round-robin, frame-granular merge of upload byte streams with a stall watchdog
module upload_arbiter #(
  parameter int          NUM_CH         = 4,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000
) (
  input  logic              clk,
  input  logic              rst_n,
  upload_arbiter_if.master  bus
);
  localparam int            CW       = $clog2(NUM_CH);
  localparam logic [CW:0]   NUM_CH_W = (CW+1)'(NUM_CH);
  localparam logic [CW-1:0] LAST_CH  = CW'(NUM_CH - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t            state, state_nx;
  logic [CW-1:0]     rr_ptr, rr_ptr_nx;
  logic [CW-1:0]     g_idx, g_idx_nx;
  logic [NUM_CH-1:0] grant_q, grant_nx;
  logic [15:0]       wd_cnt, wd_cnt_nx;
  logic [CW-1:0]     pick;
  logic              pick_ok;
  logic              xfer;
  logic              wd_fire;

  // Walk offsets from high to low so the requester nearest rr_ptr is written last and wins.
  always_comb begin
    logic [CW:0] sum;
    pick    = '0;
    pick_ok = 1'b0;
    sum     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      sum = {1'b0, rr_ptr} + (CW+1)'(i);
      if (sum >= NUM_CH_W) sum = sum - NUM_CH_W;
      if (bus.in_req[sum[CW-1:0]]) begin
        pick    = sum[CW-1:0];
        pick_ok = 1'b1;
      end
    end
  end

  // Zero-latency mux from the granted channel; everything is forced quiet outside GRANT.
  always_comb begin
    bus.out_req    = 1'b0;
    bus.out_valid  = 1'b0;
    bus.out_data   = 8'h00;
    bus.out_source = 8'h00;
    bus.in_ready   = '0;
    if (state == GRANT) begin
      bus.out_req         = bus.in_req[g_idx];
      bus.out_valid       = bus.in_valid[g_idx];
      bus.out_data        = bus.in_data[{g_idx, 3'b000} +: 8];
      bus.out_source      = bus.in_source[{g_idx, 3'b000} +: 8];
      bus.in_ready[g_idx] = bus.out_ready;
    end
  end

  assign xfer    = (state == GRANT) && bus.in_valid[g_idx] && bus.out_ready;
  // A cycle that moves a byte or ends the frame normally is never counted as a stall release.
  assign wd_fire = (TIMEOUT_CYCLES != 16'd0) && (state == GRANT) && bus.in_req[g_idx] &&
                   !xfer && (wd_cnt == TIMEOUT_CYCLES - 16'd1);

  always_comb begin
    state_nx  = state;
    rr_ptr_nx = rr_ptr;
    g_idx_nx  = g_idx;
    grant_nx  = grant_q;
    wd_cnt_nx = wd_cnt;
    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          state_nx  = GRANT;
          g_idx_nx  = pick;
          grant_nx  = {{(NUM_CH-1){1'b0}}, 1'b1} << pick;
          wd_cnt_nx = 16'd0;
        end
      end
      GRANT: begin
        if (xfer)                  wd_cnt_nx = 16'd0;
        else if (wd_cnt != 16'hFFFF) wd_cnt_nx = wd_cnt + 16'd1;
        if (!bus.in_req[g_idx] || wd_fire) begin
          state_nx  = IDLE;
          grant_nx  = '0;
          rr_ptr_nx = (g_idx == LAST_CH) ? '0 : g_idx + CW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      g_idx   <= '0;
      grant_q <= '0;
      wd_cnt  <= 16'd0;
    end else begin
      state   <= state_nx;
      rr_ptr  <= rr_ptr_nx;
      g_idx   <= g_idx_nx;
      grant_q <= grant_nx;
      wd_cnt  <= wd_cnt_nx;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.busy          = (state == GRANT);
  assign bus.timeout_pulse = wd_fire;
endmodule
